// File: rtl/cpu_mem_if.sv
// Data-memory bus between the memory stage (master) and the memory system (slave).
// Read data and ack are only meaningful while a strobe is up.
interface cpu_mem_if;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_addr, dm_wdata, dm_rd, dm_wr,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_addr, dm_wdata, dm_rd, dm_wr,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/cpu_mem.sv
// Memory-access pipeline stage. Runs one word load/store per instruction over a
// wait-state bus, stalls upstream until the access finishes (or times out), and
// registers the instruction's results for write-back.
module cpu_mem #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_stall,
  input  logic        ex_c_rfw,
  input  logic [1:0]  ex_c_wbsource,
  input  logic [1:0]  ex_c_drw,
  input  logic [31:0] ex_alu_r,
  input  logic [31:0] ex_rfb,
  input  logic [4:0]  ex_rf_waddr,
  input  logic [31:0] ex_jalra,
  cpu_mem_if.master   dm,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        p_c_rfw,
  output logic [1:0]  p_c_wbsource,
  output logic [31:0] p_alu_r,
  output logic [31:0] p_mem_r,
  output logic [4:0]  p_rf_waddr,
  output logic [31:0] p_jalra
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  // Last ACCESS cycle index before a forced completion; unused when TIMEOUT==0.
  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          bus_err_q, bus_err_d;
  logic [31:0]   hold_q, hold_d;
  logic          p_c_rfw_q, p_c_rfw_d;
  logic [1:0]    p_c_wbsource_q, p_c_wbsource_d;
  logic [31:0]   p_alu_r_q, p_alu_r_d;
  logic [31:0]   p_mem_r_q, p_mem_r_d;
  logic [4:0]    p_rf_waddr_q, p_rf_waddr_d;
  logic [31:0]   p_jalra_q, p_jalra_d;

  logic          req;
  logic          capture;
  logic [31:0]   cap_mem;

  assign req = (ex_c_drw != 2'b00);

  // Next-state, bus strobes and pipeline-register capture.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_d           = rd_q;
    wr_d           = wr_q;
    bus_err_d      = 1'b0;
    hold_d         = hold_q;
    p_c_rfw_d      = p_c_rfw_q;
    p_c_wbsource_d = p_c_wbsource_q;
    p_alu_r_d      = p_alu_r_q;
    p_mem_r_d      = p_mem_r_q;
    p_rf_waddr_d   = p_rf_waddr_q;
    p_jalra_d      = p_jalra_q;
    capture        = 1'b0;
    cap_mem        = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          // Issue regardless of cpu_stall; the instruction is held upstream
          // by mem_stall until its DONE capture.
          addr_d  = {ex_alu_r[31:2], 2'b00};
          wdata_d = ex_rfb;
          wr_d    = ex_c_drw[0];
          rd_d    = ex_c_drw[1] & ~ex_c_drw[0];
          cnt_d   = '0;
          state_d = ACCESS;
        end else if (!cpu_stall) begin
          capture = 1'b1;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (dm.dm_ack) begin
          // Ack beats a simultaneous timeout.
          hold_d  = rd_q ? dm.dm_rdata : 32'h0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          hold_d    = 32'h0;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Leaving DONE only on capture keeps the instruction from re-issuing.
        if (!cpu_stall) begin
          capture = 1'b1;
          cap_mem = hold_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      p_c_rfw_d      = ex_c_rfw;
      p_c_wbsource_d = ex_c_wbsource;
      p_alu_r_d      = ex_alu_r;
      p_mem_r_d      = cap_mem;
      p_rf_waddr_d   = ex_rf_waddr;
      p_jalra_d      = ex_jalra;
    end
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      bus_err_q      <= 1'b0;
      hold_q         <= '0;
      p_c_rfw_q      <= 1'b0;
      p_c_wbsource_q <= '0;
      p_alu_r_q      <= '0;
      p_mem_r_q      <= '0;
      p_rf_waddr_q   <= '0;
      p_jalra_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_q           <= rd_d;
      wr_q           <= wr_d;
      bus_err_q      <= bus_err_d;
      hold_q         <= hold_d;
      p_c_rfw_q      <= p_c_rfw_d;
      p_c_wbsource_q <= p_c_wbsource_d;
      p_alu_r_q      <= p_alu_r_d;
      p_mem_r_q      <= p_mem_r_d;
      p_rf_waddr_q   <= p_rf_waddr_d;
      p_jalra_q      <= p_jalra_d;
    end
  end

  assign mem_stall    = ((state_q == IDLE) && req) || (state_q == ACCESS);
  assign bus_err      = bus_err_q;
  assign dm.dm_addr   = addr_q;
  assign dm.dm_wdata  = wdata_q;
  assign dm.dm_rd     = rd_q;
  assign dm.dm_wr     = wr_q;
  assign p_c_rfw      = p_c_rfw_q;
  assign p_c_wbsource = p_c_wbsource_q;
  assign p_alu_r      = p_alu_r_q;
  assign p_mem_r      = p_mem_r_q;
  assign p_rf_waddr   = p_rf_waddr_q;
  assign p_jalra      = p_jalra_q;

endmodule

// File: tb/tb_cpu_mem.sv
// Random-instruction bench for cpu_mem: a driver issues instructions and pushes
// expected write-back results, a bus slave with planned wait states answers
// accesses, and a monitor checks each pipeline-register capture.
module tb_cpu_mem;
  localparam int TO    = 4;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_stall = 1'b0;
  logic        ex_c_rfw = 1'b0;
  logic [1:0]  ex_c_wbsource = '0;
  logic [1:0]  ex_c_drw = '0;
  logic [31:0] ex_alu_r = '0;
  logic [31:0] ex_rfb = '0;
  logic [4:0]  ex_rf_waddr = '0;
  logic [31:0] ex_jalra = '0;
  logic        mem_stall, bus_err, p_c_rfw;
  logic [1:0]  p_c_wbsource;
  logic [31:0] p_alu_r, p_mem_r, p_jalra;
  logic [4:0]  p_rf_waddr;

  always #5 clk = ~clk;

  cpu_mem_if dm();

  cpu_mem #(.TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .rst(rst), .cpu_stall(cpu_stall),
    .ex_c_rfw(ex_c_rfw), .ex_c_wbsource(ex_c_wbsource), .ex_c_drw(ex_c_drw),
    .ex_alu_r(ex_alu_r), .ex_rfb(ex_rfb), .ex_rf_waddr(ex_rf_waddr),
    .ex_jalra(ex_jalra), .dm(dm), .mem_stall(mem_stall), .bus_err(bus_err),
    .p_c_rfw(p_c_rfw), .p_c_wbsource(p_c_wbsource), .p_alu_r(p_alu_r),
    .p_mem_r(p_mem_r), .p_rf_waddr(p_rf_waddr), .p_jalra(p_jalra)
  );

  typedef struct {
    logic        rfw;
    logic [1:0]  wbs;
    logic [31:0] alu;
    logic [31:0] mem_r;
    logic [4:0]  waddr;
    logic [31:0] jalra;
    logic        to;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    int          w;
  } bus_t;

  exp_t        exp_q[$];
  bus_t        bus_q[$];
  logic [31:0] mem       [256];  // bus slave storage
  logic [31:0] model_mem [256];  // reference model's view of memory
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;
  bit          resp_en = 1'b1;
  logic        man_ack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  // Bus slave: acks each access after its planned number of wait states,
  // and throws stray acks while no access is in progress.
  initial begin
    int   cnt;
    bus_t b;
    logic [7:0] idx;
    cnt = 0;
    b = '{addr: 32'h0, wdata: 32'h0, rd: 1'b0, wr: 1'b0, w: 0};
    dm.dm_ack = 1'b0;
    dm.dm_rdata = '0;
    forever begin
      @(negedge clk);
      dm.dm_ack = 1'b0;
      dm.dm_rdata = $urandom;
      if (!resp_en) begin
        dm.dm_ack = man_ack;
        cnt = 0;
        continue;
      end
      if (dm.dm_rd || dm.dm_wr) begin
        if (cnt == 0) begin
          if (bus_q.size() == 0) begin
            n_chk++;
            $display("FAIL bus_unexpected_access: addr %h rd %b wr %b", dm.dm_addr, dm.dm_rd, dm.dm_wr);
            b.w = 0;
          end else begin
            b = bus_q.pop_front();
            chk("bus_addr", dm.dm_addr, b.addr);
            chk("bus_wdata", dm.dm_wdata, b.wdata);
            chk("bus_rdwr", 32'({dm.dm_rd, dm.dm_wr}), 32'({b.rd, b.wr}));
          end
        end
        if (cnt == b.w) begin
          idx = dm.dm_addr[9:2];
          dm.dm_ack = 1'b1;
          if (dm.dm_rd) dm.dm_rdata = mem[idx];
          if (dm.dm_wr) mem[idx] = dm.dm_wdata;
        end
        cnt++;
      end else begin
        cnt = 0;
        if ($urandom_range(0, 4) == 0) dm.dm_ack = 1'b1;
      end
    end
  end

  // Monitor: after every edge at which the stage accepts, compare the captured
  // pipeline register and the bus_err pulses seen during that instruction.
  initial begin
    bit   acc;
    int   err_seen;
    exp_t e;
    acc = 1'b0;
    err_seen = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        acc = 1'b0;
        err_seen = 0;
        continue;
      end
      if (acc) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL retire_unexpected: p_alu_r %h", p_alu_r);
        end else begin
          e = exp_q.pop_front();
          chk("p_c_rfw", 32'(p_c_rfw), 32'(e.rfw));
          chk("p_c_wbsource", 32'(p_c_wbsource), 32'(e.wbs));
          chk("p_alu_r", p_alu_r, e.alu);
          chk("p_mem_r", p_mem_r, e.mem_r);
          chk("p_rf_waddr", 32'(p_rf_waddr), 32'(e.waddr));
          chk("p_jalra", p_jalra, e.jalra);
          chk("bus_err_pulses", 32'(err_seen), 32'(e.to));
          err_seen = 0;
        end
      end
      if (bus_err) err_seen++;
      acc = !mem_stall && !cpu_stall;
    end
  end

  // Issue n random instructions, each held until the stage accepts it.
  task automatic run_ops(input int n);
    for (int i = 0; i < n; i++) begin
      int r, w, exp_stall, stall_cnt, guard;
      bit to, acc;
      logic [7:0] idx;
      exp_t e;
      bus_t b;
      r = $urandom_range(0, 9);
      ex_c_drw      = (r < 4) ? 2'b00 : (r < 7) ? 2'b10 : (r < 9) ? 2'b01 : 2'b11;
      ex_c_rfw      = 1'($urandom);
      ex_c_wbsource = 2'($urandom);
      ex_alu_r      = $urandom;
      ex_rfb        = $urandom;
      ex_rf_waddr   = 5'($urandom);
      ex_jalra      = $urandom;
      r = $urandom_range(0, 9);
      w = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, 3) : (r < 9) ? $urandom_range(4, 6) : NEVER;
      to = (ex_c_drw != 2'b00) && (w >= TO);
      idx = ex_alu_r[9:2];
      e.rfw = ex_c_rfw; e.wbs = ex_c_wbsource; e.alu = ex_alu_r;
      e.waddr = ex_rf_waddr; e.jalra = ex_jalra; e.to = to;
      e.mem_r = (ex_c_drw == 2'b10 && !to) ? model_mem[idx] : 32'h0;
      if (ex_c_drw[0] && !to) model_mem[idx] = ex_rfb;
      exp_stall = 0;
      if (ex_c_drw != 2'b00) begin
        b.addr = {ex_alu_r[31:2], 2'b00};
        b.wdata = ex_rfb;
        b.wr = ex_c_drw[0];
        b.rd = (ex_c_drw == 2'b10);
        b.w = w;
        bus_q.push_back(b);
        exp_stall = 1 + (to ? TO : w + 1);
      end
      exp_q.push_back(e);
      mon_en = 1'b1;
      stall_cnt = 0;
      guard = 0;
      do begin
        @(negedge clk);
        if (mem_stall) stall_cnt++;
        acc = !mem_stall && !cpu_stall;
        @(posedge clk);
        #1;
        cpu_stall = ($urandom_range(0, 3) == 0);
        guard++;
        if (guard > 300) begin
          n_chk++;
          $display("FAIL accept_timeout: op %0d never accepted", i);
          finish_run();
        end
      end while (!acc);
      chk("mem_stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    end
    // Bubble so the last instruction is not captured or issued again.
    ex_c_drw = 2'b00;
    cpu_stall = 1'b0;
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
  endtask

  task automatic zero_ex();
    ex_c_rfw = 1'b0; ex_c_wbsource = '0; ex_c_drw = '0; ex_alu_r = '0;
    ex_rfb = '0; ex_rf_waddr = '0; ex_jalra = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p_c_rfw"}, 32'(p_c_rfw), 32'd0);
    chk({tag, "_p_wbsource"}, 32'(p_c_wbsource), 32'd0);
    chk({tag, "_p_alu_r"}, p_alu_r, 32'd0);
    chk({tag, "_p_mem_r"}, p_mem_r, 32'd0);
    chk({tag, "_p_rf_waddr"}, 32'(p_rf_waddr), 32'd0);
    chk({tag, "_p_jalra"}, p_jalra, 32'd0);
    chk({tag, "_dm_rd"}, 32'(dm.dm_rd), 32'd0);
    chk({tag, "_dm_wr"}, 32'(dm.dm_wr), 32'd0);
    chk({tag, "_dm_addr"}, dm.dm_addr, 32'd0);
    chk({tag, "_dm_wdata"}, dm.dm_wdata, 32'd0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_mem_stall"}, 32'(mem_stall), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      model_mem[i] = mem[i];
    end
    // Reset holds while garbage (including a load) sits on the EX inputs.
    rst = 1'b0;
    ex_c_rfw = 1'b1; ex_c_drw = 2'b10; ex_alu_r = 32'h1234_5678; ex_jalra = 32'h55;
    repeat (3) @(posedge clk);
    #1;
    zero_ex();
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    run_ops(150);

    // Reset during the 2nd ACCESS cycle of a load, then a late ack.
    resp_en = 1'b0;
    man_ack = 1'b0;
    ex_c_drw = 2'b10; ex_alu_r = 32'h0000_0043; ex_rf_waddr = 5'd7; ex_c_rfw = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_dm_rd_before_reset", 32'(dm.dm_rd), 32'd1);
    chk("abort_dm_addr_before_reset", dm.dm_addr, 32'h0000_0040);
    rst = 1'b0;
    zero_ex();
    @(posedge clk); #1;
    rst = 1'b1;
    chk_all_zero("midreset");
    man_ack = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("late_ack");
    resp_en = 1'b1;

    run_ops(40);
    finish_run();
  end

endmodule
